data_mem_dump: RTL

Debug read-out engine for the single-cycle CPU's data memory. On a start pulse it sequentially reads a block of words through a synchronous memory read port and streams each word, with its address, over a valid/ready interface. It also keeps a running modular sum as a checksum. It sits beside `cpu` in simulation and FPGA debug builds, and is the reading end of the CPU's data-memory write path: testbenches drain results through it instead of probing `data_mem` directly.

---
 rtl/data_mem_dump.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/data_mem_dump.sv
`default_nettype none
// ============================================================================
// Module   : data_mem_dump
// Purpose  : Debug read-out engine for the CPU data memory. On a start pulse
//            it reads a block of words through a synchronous read port and
//            streams each word with its address over valid/ready, keeping a
//            modular running sum of the transferred words as a checksum.
// Revision : 1.0 - initial release
// ============================================================================
module data_mem_dump #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   count,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_rd_addr,
  input  logic [DATA_WIDTH-1:0] mem_rd_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [ADDR_WIDTH-1:0] out_addr,
  output logic                  out_last,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] checksum
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_READ = 3'd1;
  localparam logic [2:0] S_WAIT = 3'd2;
  localparam logic [2:0] S_SEND = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  // Largest block is the whole memory; larger requests are clamped to it.
  localparam logic [ADDR_WIDTH:0]   MAX_COUNT = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0]   REM_ONE   = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  logic [2:0]            state_q,    state_d;
  logic [ADDR_WIDTH-1:0] addr_q,     addr_d;
  logic [ADDR_WIDTH:0]   rem_q,      rem_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic [ADDR_WIDTH-1:0] out_addr_q, out_addr_d;
  logic [DATA_WIDTH-1:0] checksum_q, checksum_d;

  logic handshake;
  logic last_word;

  assign last_word = (rem_q == REM_ONE);
  assign handshake = (state_q == S_SEND) && out_ready;

  // State and datapath registers; reset returns everything to zero / IDLE.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      rem_q      <= '0;
      out_data_q <= '0;
      out_addr_q <= '0;
      checksum_q <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      rem_q      <= rem_d;
      out_data_q <= out_data_d;
      out_addr_q <= out_addr_d;
      checksum_q <= checksum_d;
    end
  end

  // Next-state logic: one read, one capture, then hold in SEND until accepted.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = (count == '0) ? S_DONE : S_READ;
        end
      end
      S_READ:  state_d = S_WAIT;
      S_WAIT:  state_d = S_SEND;
      S_SEND: begin
        if (handshake) begin
          state_d = last_word ? S_DONE : S_READ;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath updates: latch request, capture read data, account accepted words.
  always_comb begin
    addr_d     = addr_q;
    rem_d      = rem_q;
    out_data_d = out_data_q;
    out_addr_d = out_addr_q;
    checksum_d = checksum_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          addr_d     = base_addr;
          rem_d      = (count > MAX_COUNT) ? MAX_COUNT : count;
          checksum_d = '0;
        end
      end
      S_WAIT: begin
        // Read data arrives one cycle after the strobe issued in READ.
        out_data_d = mem_rd_data;
        out_addr_d = addr_q;
      end
      S_SEND: begin
        if (handshake) begin
          checksum_d = checksum_q + out_data_q;
          rem_d      = rem_q - REM_ONE;
          addr_d     = addr_q + ADDR_ONE;
        end
      end
      default: begin
      end
    endcase
  end

  // Outputs decoded from state; address lines are quiet outside READ.
  always_comb begin
    mem_rd_en   = (state_q == S_READ);
    mem_rd_addr = (state_q == S_READ) ? addr_q : '0;
    out_valid   = (state_q == S_SEND);
    out_last    = (state_q == S_SEND) && last_word;
    busy        = (state_q == S_READ) || (state_q == S_WAIT) || (state_q == S_SEND);
    done        = (state_q == S_DONE);
    out_data    = out_data_q;
    out_addr    = out_addr_q;
    checksum    = checksum_q;
  end

endmodule
`default_nettype wire
